// File: rtl/execute_control_unit_if.sv
// Issue-side and register-file-side signals of the execute control unit.
// The master is decode/issue; the slave is the execute sequencer.
interface execute_control_unit_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  instr_valid;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_en;
  logic                  latch_en;
  logic                  execute;

  modport master (
    output instr_valid, rs1, rs2,
    input  read_addr, read_en, latch_en, execute
  );

  modport slave (
    input  instr_valid, rs1, rs2,
    output read_addr, read_en, latch_en, execute
  );
endinterface

// File: rtl/execute_control_unit.sv
// Execute-stage sequencer: each accepted instruction reads rs1 (latched as
// operand A) and then rs2 (fires the ALU) on two consecutive cycles.
module execute_control_unit #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  execute_control_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_A = 2'd1,
    FETCH_B = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic                  read_en_q, read_en_d;
  logic                  latch_en_q, latch_en_d;
  logic                  execute_q, execute_d;

  // The outputs are registered copies of the next-state decode, so each
  // strobe is aligned with the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      read_addr_q <= '0;
      rs2_q       <= '0;
      read_en_q   <= 1'b0;
      latch_en_q  <= 1'b0;
      execute_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_addr_q <= read_addr_d;
      rs2_q       <= rs2_d;
      read_en_q   <= read_en_d;
      latch_en_q  <= latch_en_d;
      execute_q   <= execute_d;
    end
  end

  // read_addr already holds rs1 during FETCH_A, so only rs2 needs capturing.
  always_comb begin
    state_d     = IDLE;
    read_addr_d = read_addr_q;
    rs2_d       = rs2_q;
    read_en_d   = 1'b0;
    latch_en_d  = 1'b0;
    execute_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          state_d     = FETCH_A;
          read_addr_d = bus.rs1;
          rs2_d       = bus.rs2;
          read_en_d   = 1'b1;
          latch_en_d  = 1'b1;
        end
      end
      FETCH_A: begin
        state_d     = FETCH_B;
        read_addr_d = rs2_q;
        read_en_d   = 1'b1;
        execute_d   = 1'b1;
      end
      FETCH_B: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.read_addr = read_addr_q;
  assign bus.read_en   = read_en_q;
  assign bus.latch_en  = latch_en_q;
  assign bus.execute   = execute_q;

endmodule

// File: tb/tb_execute_control_unit.sv
// Directed bench for execute_control_unit; each task drives one scenario and
// compares {read_en, latch_en, execute, read_addr} against hand-derived values.
module tb_execute_control_unit;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  execute_control_unit_if #(.ADDR_WIDTH(AW)) bus ();

  execute_control_unit #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW+2:0] obs();
    return {bus.read_en, bus.latch_en, bus.execute, bus.read_addr};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [AW+2:0] exp;
    rst = 1'b0;
    bus.instr_valid = 1'b0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    #12;
    exp = {3'b000, 5'd0};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL reset_state: got %b expected %b", obs(), exp);
    end
    step();
    rst = 1'b1;
    step();
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL reset_release: got %b expected %b", obs(), exp);
    end
  endtask

  task automatic test_idle_hold();
    logic [AW+2:0] exp;
    bus.instr_valid = 1'b0;
    bus.rs1 = 5'd10;
    bus.rs2 = 5'd20;
    exp = {3'b000, 5'd0};
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("[TB] FAIL idle_hold[%0d]: got %b expected %b", i, obs(), exp);
      end
    end
  endtask

  task automatic test_basic();
    logic [AW-1:0] a_tab [7] = '{5'd1, 5'd0, 5'd15, 5'd31, 5'd5, 5'd0, 5'd31};
    logic [AW-1:0] b_tab [7] = '{5'd2, 5'd31, 5'd16, 5'd0, 5'd5, 5'd0, 5'd31};
    logic [AW+2:0] exp;
    for (int i = 0; i < 7; i++) begin
      bus.instr_valid = 1'b1;
      bus.rs1 = a_tab[i];
      bus.rs2 = b_tab[i];
      step();
      bus.instr_valid = 1'b0;
      exp = {3'b110, a_tab[i]};
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("[TB] FAIL basic_fetch_a[%0d]: got %b expected %b", i, obs(), exp);
      end
      step();
      exp = {3'b101, b_tab[i]};
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("[TB] FAIL basic_fetch_b[%0d]: got %b expected %b", i, obs(), exp);
      end
      step();
      exp = {3'b000, b_tab[i]};
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("[TB] FAIL basic_idle[%0d]: got %b expected %b", i, obs(), exp);
      end
    end
  endtask

  task automatic test_capture();
    logic [AW+2:0] exp;
    bus.instr_valid = 1'b1;
    bus.rs1 = 5'd7;
    bus.rs2 = 5'd9;
    step();
    // instr_valid stays high through FETCH_A and must be ignored there
    bus.rs1 = 5'd30;
    bus.rs2 = 5'd30;
    exp = {3'b110, 5'd7};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL capture_fetch_a: got %b expected %b", obs(), exp);
    end
    step();
    bus.instr_valid = 1'b0;
    exp = {3'b101, 5'd9};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL capture_fetch_b: got %b expected %b", obs(), exp);
    end
    step();
    exp = {3'b000, 5'd9};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL capture_idle: got %b expected %b", obs(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW+2:0] exp;
    bus.instr_valid = 1'b1;
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd4;
    step();
    bus.instr_valid = 1'b0;
    exp = {3'b110, 5'd3};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL b2b_first_a: got %b expected %b", obs(), exp);
    end
    step();
    exp = {3'b101, 5'd4};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL b2b_first_b: got %b expected %b", obs(), exp);
    end
    step();
    bus.instr_valid = 1'b1;
    bus.rs1 = 5'd11;
    bus.rs2 = 5'd12;
    exp = {3'b000, 5'd4};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL b2b_gap_idle: got %b expected %b", obs(), exp);
    end
    step();
    bus.instr_valid = 1'b0;
    exp = {3'b110, 5'd11};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL b2b_second_a: got %b expected %b", obs(), exp);
    end
    step();
    exp = {3'b101, 5'd12};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL b2b_second_b: got %b expected %b", obs(), exp);
    end
    step();
    exp = {3'b000, 5'd12};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL b2b_final_idle: got %b expected %b", obs(), exp);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW+2:0] exp;
    for (int i = 0; i < 20; i++) begin
      a = AW'($urandom_range(0, 31));
      b = AW'($urandom_range(0, 31));
      bus.instr_valid = 1'b1;
      bus.rs1 = a;
      bus.rs2 = b;
      step();
      bus.instr_valid = 1'b0;
      bus.rs1 = ~a;
      bus.rs2 = ~b;
      exp = {3'b110, a};
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("[TB] FAIL rand_fetch_a[%0d]: got %b expected %b", i, obs(), exp);
      end
      step();
      exp = {3'b101, b};
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("[TB] FAIL rand_fetch_b[%0d]: got %b expected %b", i, obs(), exp);
      end
      step();
      exp = {3'b000, b};
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("[TB] FAIL rand_idle[%0d]: got %b expected %b", i, obs(), exp);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [AW+2:0] exp;
    bus.instr_valid = 1'b1;
    bus.rs1 = 5'd6;
    bus.rs2 = 5'd8;
    step();
    bus.instr_valid = 1'b0;
    exp = {3'b110, 5'd6};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL abort_fetch_a: got %b expected %b", obs(), exp);
    end
    #2;
    rst = 1'b0;
    #1;
    exp = {3'b000, 5'd0};
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("[TB] FAIL abort_async_clear: got %b expected %b", obs(), exp);
    end
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (obs() !== exp) begin
        bad++;
        $display("[TB] FAIL abort_no_strobe[%0d]: got %b expected %b", i, obs(), exp);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_idle_hold();
    test_basic();
    test_capture();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
